// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, sequencer states and op classification for seq_alu
package alu_pkg;
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_MUL  = 2;
  localparam int OP_DIV  = 3;
  localparam int OP_SHL  = 4;
  localparam int OP_SHR  = 5;
  localparam int OP_ROL  = 6;
  localparam int OP_ROR  = 7;
  localparam int OP_AND  = 8;
  localparam int OP_OR   = 9;
  localparam int OP_XOR  = 10;
  localparam int OP_NOR  = 11;
  localparam int OP_NAND = 12;
  localparam int OP_XNOR = 13;
  localparam int OP_GT   = 14;
  localparam int OP_EQ   = 15;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  function automatic logic is_multi(input int op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: shared iterative shift-add multiply / restoring divide, lo/hi show the value after the current step
module seq_alu_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             last
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] acc, q, m;
  logic [CW-1:0] cnt;
  logic div_q;
  logic [WIDTH:0] sum, sh, diff;
  always_comb begin
    sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    sh   = {acc, q[WIDTH-1]};
    diff = sh - {1'b0, m};
    hi   = div_q ? (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    lo   = div_q ? {q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], q[WIDTH-1:1]};
    last = cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk)
    if (reset) begin
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc   <= '0;
      q     <= op1;
      m     <= op2;
      cnt   <= '0;
      div_q <= is_div;
    end else begin
      acc <= hi;
      q   <= lo;
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with single-cycle logic/arith ops, iterative MUL/DIV and status flags
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             div_by_zero
);
  state_t state, state_nx;
  logic accept, is_div, dbz_req, load, last, sc_c;
  logic [WIDTH-1:0] md_lo, md_hi, sc_res;
  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk(clk), .reset(reset), .load(load), .is_div(is_div),
    .op1(operand1), .op2(operand2), .lo(md_lo), .hi(md_hi), .last(last)
  );
  always_comb begin
    busy     = state == MUL || state == DIV;
    done     = state == DONE;
    accept   = start && !busy;
    is_div   = int'(opcode) == OP_DIV;
    dbz_req  = is_div && operand2 == '0;
    load     = accept && is_multi(int'(opcode)) && !dbz_req;
    state_nx = busy ? (last ? DONE : state) : accept ? (!load ? DONE : is_div ? DIV : MUL) : IDLE;
  end
  always_comb begin
    sc_c   = 1'b0;
    sc_res = '0;
    case (int'(opcode))
      OP_ADD:  {sc_c, sc_res} = {1'b0, operand1} + {1'b0, operand2};
      OP_SUB:  {sc_c, sc_res} = {1'b0, operand1} - {1'b0, operand2};
      OP_SHL:  {sc_c, sc_res} = {operand1, 1'b0};
      OP_SHR:  {sc_res, sc_c} = {1'b0, operand1};
      OP_ROL:  {sc_c, sc_res} = {operand1, operand1[WIDTH-1]};
      OP_ROR:  {sc_res, sc_c} = {operand1[0], operand1};
      OP_AND:  sc_res = operand1 & operand2;
      OP_OR:   sc_res = operand1 | operand2;
      OP_XOR:  sc_res = operand1 ^ operand2;
      OP_NOR:  sc_res = ~(operand1 | operand2);
      OP_NAND: sc_res = ~(operand1 & operand2);
      OP_XNOR: sc_res = ~(operand1 ^ operand2);
      OP_GT:   sc_res = WIDTH'(operand1 > operand2);
      OP_EQ:   sc_res = WIDTH'(operand1 == operand2);
      default: ;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state       <= IDLE;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      carry       <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (busy && last) begin
        result      <= md_lo;
        result_hi   <= md_hi;
        zero        <= state == MUL ? {md_hi, md_lo} == '0 : md_lo == '0;
        carry       <= 1'b0;
        div_by_zero <= 1'b0;
      end else if (accept && !load) begin
        result      <= dbz_req ? '1 : sc_res;
        result_hi   <= dbz_req ? operand1 : '0;
        zero        <= !dbz_req && sc_res == '0;
        carry       <= !dbz_req && sc_c;
        div_by_zero <= dbz_req;
      end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with an arithmetic reference model checked every cycle
module tb_seq_alu;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] opcode = '0;
  logic [15:0] operand1 = '0, operand2 = '0;
  logic busy, done, zero, carry, div_by_zero;
  logic [15:0] result, result_hi;
  int checks = 0, errors = 0;
  logic armed = 1'b0;
  seq_alu #(.WIDTH(16), .OP_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .operand1(operand1), .operand2(operand2), .busy(busy), .done(done),
    .result(result), .result_hi(result_hi), .zero(zero), .carry(carry),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic z;
    logic c;
    logic dbz;
  } exp_t;
  function automatic exp_t model_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int ai, bi;
    logic [31:0] p;
    e = '0;
    ai = int'(a);
    bi = int'(b);
    p = 32'(ai) * 32'(bi);
    case (op)
      4'h0: begin e.res = 16'(ai + bi); e.c = (ai + bi) > 65535; end
      4'h1: begin e.res = 16'(ai - bi); e.c = ai < bi; end
      4'h2: begin e.res = p[15:0]; e.hi = p[31:16]; end
      4'h3: if (bi == 0) begin e.res = 16'hFFFF; e.hi = a; e.dbz = 1'b1; end
            else begin e.res = 16'(ai / bi); e.hi = 16'(ai % bi); end
      4'h4: begin e.res = 16'(ai * 2); e.c = ai >= 32768; end
      4'h5: begin e.res = 16'(ai / 2); e.c = (ai % 2) == 1; end
      4'h6: begin e.res = 16'((ai * 2) % 65536 + ai / 32768); e.c = ai >= 32768; end
      4'h7: begin e.res = 16'(ai / 2 + (ai % 2) * 32768); e.c = (ai % 2) == 1; end
      4'h8: e.res = a & b;
      4'h9: e.res = a | b;
      4'hA: e.res = a ^ b;
      4'hB: e.res = ~(a | b);
      4'hC: e.res = ~(a & b);
      4'hD: e.res = ~(a ^ b);
      4'hE: e.res = (ai > bi) ? 16'd1 : 16'd0;
      default: e.res = (ai == bi) ? 16'd1 : 16'd0;
    endcase
    e.z = (op == 4'h2) ? p == 0 : e.res == 0;
    return e;
  endfunction
  function automatic int model_lat(input logic [3:0] op, input logic [15:0] b);
    return (op == 4'h2 || (op == 4'h3 && b != 0)) ? 17 : 1;
  endfunction
  exp_t m_cur, m_pend;
  logic m_busy, m_done;
  int m_left;
  always @(posedge clk)
    if (reset) begin
      m_cur  <= '0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
    end else if (start && !m_busy) begin
      if (model_lat(opcode, operand2) == 1) begin
        m_cur  <= model_op(opcode, operand1, operand2);
        m_done <= 1'b1;
      end else begin
        m_pend <= model_op(opcode, operand1, operand2);
        m_busy <= 1'b1;
        m_done <= 1'b0;
        m_left <= 15;
      end
    end else if (m_busy && m_left == 0) begin
      m_cur  <= m_pend;
      m_busy <= 1'b0;
      m_done <= 1'b1;
    end else begin
      m_left <= m_left - 1;
      m_done <= 1'b0;
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (armed) begin
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_result", 32'(result), 32'(m_cur.res));
      chk("cyc_result_hi", 32'(result_hi), 32'(m_cur.hi));
      chk("cyc_zero", 32'(zero), 32'(m_cur.z));
      chk("cyc_carry", 32'(carry), 32'(m_cur.c));
      chk("cyc_dbz", 32'(div_by_zero), 32'(m_cur.dbz));
    end
  task automatic fire(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    start = 1'b1;
    opcode = op;
    operand1 = a;
    operand2 = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input string name, output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) break;
    end
    if (!done) begin
      chk({name, "_timeout"}, 32'(done), 32'd1);
      lat = -1;
    end
  endtask
  task automatic run(input string name, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input int lat_e, input int bsy_e, input logic [15:0] res_e, input logic [15:0] hi_e,
                     input logic c_e, input logic z_e, input logic d_e);
    int lat, bcnt;
    @(posedge clk);
    #1 fire(op, a, b);
    wait_done(name, lat, bcnt);
    chk({name, "_latency"}, 32'(lat), 32'(lat_e));
    chk({name, "_busy_cycles"}, 32'(bcnt), 32'(bsy_e));
    chk({name, "_result"}, 32'(result), 32'(res_e));
    chk({name, "_result_hi"}, 32'(result_hi), 32'(hi_e));
    chk({name, "_carry"}, 32'(carry), 32'(c_e));
    chk({name, "_zero"}, 32'(zero), 32'(z_e));
    chk({name, "_dbz"}, 32'(div_by_zero), 32'(d_e));
  endtask
  initial begin
    int lat, bcnt, dcnt;
    @(posedge clk);
    armed = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    run("add_wrap", 4'h0, 16'hFFFF, 16'h0001, 1, 0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    run("mul", 4'h2, 16'h0123, 16'h0456, 17, 16, 16'hEDC2, 16'h0004, 1'b0, 1'b0, 1'b0);
    run("div", 4'h3, 16'h03E8, 16'h0007, 17, 16, 16'h008E, 16'h0006, 1'b0, 1'b0, 1'b0);
    run("div_zero", 4'h3, 16'h1234, 16'h0000, 1, 0, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b1);
    run("rol", 4'h6, 16'h8001, 16'h0000, 1, 0, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b0);
    run("sub_borrow", 4'h1, 16'h0003, 16'h0005, 1, 0, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0);
    run("gt", 4'hE, 16'h0005, 16'h0003, 1, 0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
    run("eq", 4'hF, 16'h0005, 16'h0003, 1, 0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    run("shr", 4'h5, 16'h0001, 16'h0000, 1, 0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    run("ror", 4'h7, 16'h0001, 16'h0000, 1, 0, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0);
    run("shl", 4'h4, 16'h4001, 16'h0000, 1, 0, 16'h8002, 16'h0000, 1'b0, 1'b0, 1'b0);
    run("xnor", 4'hD, 16'hF0F0, 16'h0F0F, 1, 0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    run("nor", 4'hB, 16'hF000, 16'h000F, 1, 0, 16'h0FF0, 16'h0000, 1'b0, 1'b0, 1'b0);
    run("mul_zero", 4'h2, 16'h0000, 16'hBEEF, 17, 16, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    run("div_small", 4'h3, 16'h0003, 16'h0009, 17, 16, 16'h0000, 16'h0003, 1'b0, 1'b1, 1'b0);
    run("mul_max", 4'h2, 16'hFFFF, 16'hFFFF, 17, 16, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 fire(4'h2, 16'h0123, 16'h0456);
    repeat (3) @(posedge clk);
    #1 fire(4'h0, 16'h0001, 16'h0001);
    wait_done("mul_ignore", lat, bcnt);
    chk("mul_ignore_result", 32'(result), 32'h0000EDC2);
    chk("mul_ignore_result_hi", 32'(result_hi), 32'h00000004);
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("mul_ignore_extra_done", 32'(dcnt), 32'd0);
    run("b2b_first", 4'h0, 16'h0001, 16'h0001, 1, 0, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0);
    fire(4'hA, 16'hAAAA, 16'h5555);
    wait_done("b2b_second", lat, bcnt);
    chk("b2b_second_latency", 32'(lat), 32'd1);
    chk("b2b_second_result", 32'(result), 32'h0000FFFF);
    @(posedge clk);
    #1 fire(4'h3, 16'h03E8, 16'h0007);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_hi", 32'(result_hi), 32'd0);
    chk("rst_flags", {29'd0, zero, carry, div_by_zero}, 32'd0);
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("rst_no_done", 32'(dcnt), 32'd0);
    run("add_after_rst", 4'h0, 16'h0002, 16'h0003, 1, 0, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
